// File: rtl/cmd_scheduler.sv
// Command scheduler: queues {ctrl, duration} commands in a small FIFO and
// plays each one onto ctrl_out for exactly its duration in sclk cycles,
// strictly in arrival order, with an optional idle gap between commands.
module cmd_scheduler #(
    parameter int          DEPTH    = 4,
    parameter int          GAP_CYC  = 1,
    parameter logic [7:0]  IDLE_VAL = 8'h00
) (
    input  logic                      sclk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    input  logic [7:0]                cmd_ctrl,
    input  logic [31:0]               cmd_time,
    input  logic                      abort,
    input  logic                      clr_ovf,
    output logic [7:0]                ctrl_out,
    output logic                      active,
    output logic                      busy,
    output logic                      cmd_done,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // Gap counter only needs to hold GAP_CYC-1; keep at least one bit so
    // the design still elaborates when the gap is disabled.
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [31:0]     cnt;
    logic [31:0]     cnt_n;
    logic [GW-1:0]   gap_cnt;
    logic [GW-1:0]   gap_cnt_n;
    logic [7:0]      ctrl_out_n;
    logic            active_n;
    logic            cmd_done_n;

    logic [39:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;

    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push_ok;
    logic            drop;
    logic [7:0]      head_ctrl;
    logic [31:0]     head_time;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LW'(DEPTH));
    assign head_ctrl  = mem[rd_ptr][39:32];
    assign head_time  = mem[rd_ptr][31:0];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted when the FSM is taking the head entry.
    assign push_ok = cmd_valid && !abort && (!fifo_full || pop);
    assign drop    = cmd_valid && !abort && fifo_full && !pop;

    assign fifo_level = level;
    assign busy       = (state != IDLE) || (level != '0);

    // Next-state and next-output logic; abort forces an immediate return to idle.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        gap_cnt_n  = gap_cnt;
        ctrl_out_n = ctrl_out;
        active_n   = active;
        cmd_done_n = 1'b0;
        pop        = 1'b0;
        if (abort) begin
            state_n    = IDLE;
            cnt_n      = '0;
            gap_cnt_n  = '0;
            ctrl_out_n = IDLE_VAL;
            active_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (head_time == 32'd0) begin
                            cmd_done_n = 1'b1;
                        end else begin
                            cnt_n      = head_time - 32'd1;
                            ctrl_out_n = head_ctrl;
                            active_n   = 1'b1;
                            state_n    = RUN;
                        end
                    end
                end
                RUN: begin
                    if (cnt != 32'd0) begin
                        cnt_n = cnt - 32'd1;
                    end else begin
                        ctrl_out_n = IDLE_VAL;
                        active_n   = 1'b0;
                        cmd_done_n = 1'b1;
                        if (GAP_CYC > 0) begin
                            state_n   = GAP;
                            gap_cnt_n = GW'(GAP_CYC - 1);
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state_n = IDLE;
                    end else begin
                        gap_cnt_n = gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // FSM and output registers.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            gap_cnt  <= '0;
            ctrl_out <= IDLE_VAL;
            active   <= 1'b0;
            cmd_done <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            gap_cnt  <= gap_cnt_n;
            ctrl_out <= ctrl_out_n;
            active   <= active_n;
            cmd_done <= cmd_done_n;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge sclk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= {cmd_ctrl, cmd_time};
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge sclk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(push_ok) - LW'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
